// File: rtl/udp_rx_frame_ctrl.sv
// UDP receive frame buffer: commits good frames into a word buffer and streams them out.
// Define RX_DROP_ERR_EN to drop frames that see err_flag while open or at rec_end.
module udp_rx_frame_ctrl #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned FRAMES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rec_data_en,
  input  logic [31:0] rec_data,
  input  logic        rec_end,
  input  logic [15:0] rec_data_num,
  input  logic        err_flag,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic [15:0] m_len,
  output logic [15:0] drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(FRAMES);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = CW + 16;

  typedef logic [AW:0] ptr_t;
  typedef logic [FW:0] dptr_t;

  localparam ptr_t  DepthP  = ptr_t'(DEPTH);
  localparam dptr_t FramesP = dptr_t'(FRAMES);
  localparam ptr_t  POne    = ptr_t'(1);
  localparam ptr_t  PTwo    = ptr_t'(2);
  localparam dptr_t DOne    = dptr_t'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

  logic [31:0]   buf_mem  [DEPTH];
  logic [DW-1:0] desc_mem [FRAMES];

  // Write side
  ptr_t        wr_ptr_q, commit_ptr_q, wcnt_q;
  logic        bad_q, open_q;
  logic [15:0] drop_cnt_q;
  dptr_t       dq_wr_q;

  // Read side
  state_e      state_q, state_d;
  ptr_t        rd_ptr_q, rem_q;
  dptr_t       dq_rd_q, dq_rel_q;
  logic [31:0] m_data_q;
  logic        m_last_q;
  logic [15:0] m_len_q;

  logic buf_full, desc_full, err_hit, full_hit, do_write;
  logic frame_empty, frame_bad, commit, drop;
  ptr_t wr_next, wcnt_next;

  always_comb begin
    buf_full  = (wr_ptr_q - rd_ptr_q) == DepthP;
    // A descriptor stays counted until its frame has fully streamed out, so
    // the frame currently on the output occupies one of the FRAMES slots.
    desc_full = (dq_wr_q - dq_rel_q) == FramesP;
`ifdef RX_DROP_ERR_EN
    err_hit   = err_flag && (open_q || rec_data_en || rec_end);
`else
    err_hit   = 1'b0;
`endif
    full_hit    = rec_data_en && !bad_q && buf_full;
    do_write    = rec_data_en && !bad_q && !buf_full;
    wr_next     = wr_ptr_q + ptr_t'(do_write);
    wcnt_next   = wcnt_q + ptr_t'(do_write);
    // Empty frames carry no words to stream and are silently ignored.
    frame_empty = (wcnt_next == '0) && !bad_q && !full_hit && !err_hit;
    frame_bad   = bad_q || full_hit || err_hit || desc_full;
    commit      = rec_end && !frame_empty && !frame_bad;
    drop        = rec_end && !frame_empty && frame_bad;
  end

`ifndef RX_DROP_ERR_EN
  logic unused_err;
  assign unused_err = ^{err_flag, open_q};
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      wcnt_q       <= '0;
      bad_q        <= 1'b0;
      open_q       <= 1'b0;
      drop_cnt_q   <= '0;
      dq_wr_q      <= '0;
    end else begin
      if (rec_end) begin
        wr_ptr_q <= drop ? commit_ptr_q : wr_next;
        wcnt_q   <= '0;
        bad_q    <= 1'b0;
        open_q   <= 1'b0;
      end else begin
        wr_ptr_q <= wr_next;
        wcnt_q   <= wcnt_next;
        if (full_hit || err_hit) bad_q <= 1'b1;
        if (rec_data_en) open_q <= 1'b1;
      end
      if (commit) begin
        commit_ptr_q <= wr_next;
        dq_wr_q      <= dq_wr_q + DOne;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_write) buf_mem[wr_ptr_q[AW-1:0]] <= rec_data;
    if (commit) desc_mem[dq_wr_q[FW-1:0]] <= {wcnt_next, rec_data_num};
  end

  logic          pop, xfer, last_xfer, pending;
  logic [DW-1:0] desc_head;
  ptr_t          head_words, rd_next;

  assign desc_head  = desc_mem[dq_rd_q[FW-1:0]];
  assign head_words = desc_head[DW-1:16];
  assign rd_next    = rd_ptr_q + POne;
  assign pending    = dq_rd_q != dq_wr_q;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending) state_d = StLoad;
      end
      StLoad: begin
        pop     = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        if (m_ready) begin
          xfer = 1'b1;
          if (m_last_q) begin
            last_xfer = 1'b1;
            state_d   = pending ? StLoad : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      rem_q    <= '0;
      dq_rd_q  <= '0;
      dq_rel_q <= '0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
      m_len_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        dq_rd_q  <= dq_rd_q + DOne;
        m_len_q  <= desc_head[15:0];
        rem_q    <= head_words;
        m_data_q <= buf_mem[rd_ptr_q[AW-1:0]];
        m_last_q <= head_words == POne;
      end
      if (xfer) begin
        rd_ptr_q <= rd_next;
        if (last_xfer) begin
          m_last_q <= 1'b0;
          dq_rel_q <= dq_rel_q + DOne;
        end else begin
          rem_q    <= rem_q - POne;
          m_data_q <= buf_mem[rd_next[AW-1:0]];
          m_last_q <= rem_q == PTwo;
        end
      end
    end
  end

  assign m_valid  = state_q == StStream;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign m_len    = m_len_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_frame_ctrl.sv
// Directed bench for udp_rx_frame_ctrl (DEPTH=16, FRAMES=4); honours RX_DROP_ERR_EN.
module tb_udp_rx_frame_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        rec_data_en;
  logic [31:0] rec_data;
  logic        rec_end;
  logic [15:0] rec_data_num;
  logic        err_flag;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [15:0] m_len;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  udp_rx_frame_ctrl #(
    .DEPTH (16),
    .FRAMES(4)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .rec_data_en (rec_data_en),
    .rec_data    (rec_data),
    .rec_end     (rec_end),
    .rec_data_num(rec_data_num),
    .err_flag    (err_flag),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_len       (m_len),
    .drop_cnt    (drop_cnt)
  );

  typedef struct {
    logic        en;
    logic [31:0] data;
    logic        fend;
    logic [15:0] num;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [15:0] elen;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [31:0] base, input int i);
    return base + 32'(i);
  endfunction

  task automatic idle_in();
    rec_data_en  = 1'b0;
    rec_data     = '0;
    rec_end      = 1'b0;
    rec_data_num = '0;
    err_flag     = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    idle_in();
    m_ready = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Drives n consecutive words; rec_end rides on the last one. Inputs are left
  // asserted so back-to-back calls produce back-to-back frames.
  task automatic send_frame(input int n, input logic [31:0] base, input logic [15:0] num,
                            input int err_idx);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      rec_data_en  = 1'b1;
      rec_data     = wd(base, i);
      rec_end      = (i == n - 1);
      rec_data_num = (i == n - 1) ? num : 16'd0;
      err_flag     = (i == err_idx);
    end
  endtask

  task automatic drain(input string name, input int n, input logic [31:0] base,
                       input logic [15:0] len, input bit toggle);
    int got = 0;
    int cyc = 0;
    bit stall = 0;
    logic [31:0] held = '0;
    while (got < n && cyc < 200) begin
      @(negedge sys_clk);
      cyc++;
      m_ready = toggle ? cyc[0] : 1'b1;
      if (m_valid) begin
        if (stall) chk({name, " hold"}, m_data, held);
        chk({name, " data"}, m_data, wd(base, got));
        chk({name, " last"}, 32'(m_last), 32'(got == n - 1));
        chk({name, " len"}, 32'(m_len), 32'(len));
        if (m_ready) begin
          got++;
          stall = 0;
        end else begin
          stall = 1;
          held  = m_data;
        end
      end
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s count: got %0d words expected %0d", name, got, n);
    end
  endtask

  // Returns 1 if m_valid was seen high in any of the next n cycles.
  task automatic watch_valid(input int n, output bit seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (m_valid) seen = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    int cyc;

    vt[0] = '{1'b1, 32'h01020304, 1'b0, 16'd0,  1'b0, 32'h0,        1'b0, 16'd0};
    vt[1] = '{1'b1, 32'h05060708, 1'b0, 16'd0,  1'b0, 32'h0,        1'b0, 16'd0};
    vt[2] = '{1'b1, 32'h090A0B0C, 1'b1, 16'd12, 1'b0, 32'h0,        1'b0, 16'd0};
    vt[3] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b0, 32'h0,        1'b0, 16'd0};
    vt[4] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b0, 32'h0,        1'b0, 16'd0};
    vt[5] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b1, 32'h01020304, 1'b0, 16'd12};
    vt[6] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b1, 32'h05060708, 1'b0, 16'd12};
    vt[7] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b1, 32'h090A0B0C, 1'b1, 16'd12};
    vt[8] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b0, 32'h0,        1'b0, 16'd0};
    vt[9] = '{1'b0, 32'h0,        1'b0, 16'd0,  1'b0, 32'h0,        1'b0, 16'd0};

    idle_in();
    m_ready = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    chk("reset m_valid", 32'(m_valid), 32'h0);
    chk("reset m_data", m_data, 32'h0);
    chk("reset m_last", 32'(m_last), 32'h0);
    chk("reset m_len", 32'(m_len), 32'h0);
    chk("reset drop_cnt", 32'(drop_cnt), 32'h0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

    // 12-byte frame, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      chk($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("vec%0d m_data", i), m_data, vt[i].ed);
        chk($sformatf("vec%0d m_last", i), 32'(m_last), 32'(vt[i].el));
        chk($sformatf("vec%0d m_len", i), 32'(m_len), 32'(vt[i].elen));
      end
      rec_data_en  = vt[i].en;
      rec_data     = vt[i].data;
      rec_end      = vt[i].fend;
      rec_data_num = vt[i].num;
      m_ready      = 1'b1;
    end
    chk("frame12 drop_cnt", 32'(drop_cnt), 32'h0);

    // Backpressure over a 5-word frame
    do_reset();
    send_frame(5, 32'hA000_0000, 16'd20, -1);
    @(negedge sys_clk);
    idle_in();
    drain("bp", 5, 32'hA000_0000, 16'd20, 1'b1);
    watch_valid(4, seen);
    chk("bp idle after", 32'(seen), 32'h0);

    // Overflow: 20 words into a 16-word buffer
    do_reset();
    send_frame(20, 32'hB000_0000, 16'd80, -1);
    @(negedge sys_clk);
    idle_in();
    watch_valid(8, seen);
    chk("ovf no valid", 32'(seen), 32'h0);
    chk("ovf drop_cnt", 32'(drop_cnt), 32'h1);
    send_frame(4, 32'hB100_0000, 16'd16, -1);
    @(negedge sys_clk);
    idle_in();
    drain("ovf next", 4, 32'hB100_0000, 16'd16, 1'b0);
    chk("ovf drop_cnt after", 32'(drop_cnt), 32'h1);

    // err_flag on word 2 of 4
    do_reset();
    send_frame(4, 32'hC000_0000, 16'd16, 1);
    @(negedge sys_clk);
    idle_in();
`ifdef RX_DROP_ERR_EN
    watch_valid(8, seen);
    chk("err no valid", 32'(seen), 32'h0);
    chk("err drop_cnt", 32'(drop_cnt), 32'h1);
`else
    m_ready = 1'b1;
    drain("err ignored", 4, 32'hC000_0000, 16'd16, 1'b0);
    chk("err drop_cnt", 32'(drop_cnt), 32'h0);
`endif

    // Descriptor queue full: 5 back-to-back 1-word frames, downstream stalled
    do_reset();
    for (int k = 0; k < 5; k++) send_frame(1, 32'hD000_0000 + 32'(k), 16'd4, -1);
    @(negedge sys_clk);
    idle_in();
    repeat (4) @(negedge sys_clk);
    chk("dq drop_cnt", 32'(drop_cnt), 32'h1);
    for (int k = 0; k < 4; k++)
      drain($sformatf("dq frame%0d", k), 1, 32'hD000_0000 + 32'(k), 16'd4, 1'b0);
    watch_valid(8, seen);
    chk("dq fifth absent", 32'(seen), 32'h0);

    // Reset on the second of three output words
    do_reset();
    send_frame(3, 32'hE000_0000, 16'd12, -1);
    @(negedge sys_clk);
    idle_in();
    m_ready = 1'b1;
    cyc = 0;
    while (!m_valid && cyc < 20) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("rst first word", m_data, 32'hE000_0000);
    @(negedge sys_clk);
    chk("rst second word", m_data, 32'hE000_0001);
    sys_rst = 1'b1;
    #1;
    chk("rst m_valid", 32'(m_valid), 32'h0);
    chk("rst m_data", m_data, 32'h0);
    chk("rst m_last", 32'(m_last), 32'h0);
    chk("rst m_len", 32'(m_len), 32'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    watch_valid(10, seen);
    chk("rst no stale valid", 32'(seen), 32'h0);
    send_frame(2, 32'hF000_0000, 16'd8, -1);
    @(negedge sys_clk);
    idle_in();
    drain("post rst", 2, 32'hF000_0000, 16'd8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
